// File: rtl/mips_cpu_sequencer_if.sv
// mips_cpu_sequencer_if
//   Bus bundle between the multicycle sequencer and the rest of the core.
//   slave  : the sequencer (consumes decode/memory/PC status, drives state + status)
//   master : the surrounding core / testbench
// Signals:
//   clk_enable      core-wide enable; 0 freezes the sequencer
//   opcode, fncode  instruction-register fields [31:26] and [5:0]
//   mem_waitrequest memory not ready, current access must be held
//   pc_is_zero      PC-next equals 0x00000000
//   state           registered sequencer state (0..6)
//   active, stall   status flags
//   fault           sticky illegal-instruction flag
//   instr_count     retired instructions
//   cycle_count     enabled cycles spent active
interface mips_cpu_sequencer_if;
  logic        clk_enable;
  logic [5:0]  opcode;
  logic [5:0]  fncode;
  logic        mem_waitrequest;
  logic        pc_is_zero;
  logic [2:0]  state;
  logic        active;
  logic        stall;
  logic        fault;
  logic [31:0] instr_count;
  logic [31:0] cycle_count;

  modport slave (
    input  clk_enable, opcode, fncode, mem_waitrequest, pc_is_zero,
    output state, active, stall, fault, instr_count, cycle_count
  );

  modport master (
    output clk_enable, opcode, fncode, mem_waitrequest, pc_is_zero,
    input  state, active, stall, fault, instr_count, cycle_count
  );
endinterface

// File: rtl/mips_cpu_sequencer.sv
// mips_cpu_sequencer
//   Multicycle state sequencer: IDLE -> FETCH -> DECODE -> EXEC1 -> [EXEC2],
//   repeating per instruction. Memory states stretch on mem_waitrequest,
//   unsupported instructions trap to FAULT, and the core halts when the
//   PC-next is zero at the end of an instruction.
// Ports:
//   clk    core clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mips_cpu_sequencer_if.slave (see interface for signal list)
// Parameter:
//   HALT_ADDR_ZERO  1 = halt when pc_is_zero at end of instruction, 0 = ignore
// Build option:
//   MIPS_SEQ_PERF_COUNT_EN  defined   -> instr_count / cycle_count implemented
//                           undefined -> both counters read 32'h0
module mips_cpu_sequencer #(
  parameter int HALT_ADDR_ZERO = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_cpu_sequencer_if.slave   bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC1  = 3'd3;
  localparam logic [2:0] S_EXEC2  = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       r_fault;
  logic       w_long;
  logic       w_short;
  logic       w_stall;
  logic       w_active;
  logic [2:0] w_end_state;

  // Instruction class decode
  always_comb begin
    w_long  = ((bus.opcode == OP_RTYPE) && (bus.fncode >= 6'h20) && (bus.fncode <= 6'h26))
           || (bus.opcode == OP_LW) || (bus.opcode == OP_SW);
    w_short = (bus.opcode == OP_BEQ)
           || ((bus.opcode == OP_RTYPE) && ((bus.fncode == FN_JR) || (bus.fncode == FN_JALR)));
  end

  // Only a memory state can be held; waitrequest elsewhere is ignored
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_FETCH: w_stall = bus.mem_waitrequest;
      S_EXEC1: w_stall = bus.mem_waitrequest && (bus.opcode == OP_LW);
      S_EXEC2: w_stall = bus.mem_waitrequest && (bus.opcode == OP_SW);
      default: w_stall = 1'b0;
    endcase
  end

  assign w_active    = (r_state >= S_FETCH) && (r_state <= S_EXEC2);
  assign w_end_state = ((HALT_ADDR_ZERO != 0) && bus.pc_is_zero) ? S_HALTED : S_FETCH;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (!w_stall) w_next = S_DECODE;
      S_DECODE: w_next = (w_long || w_short) ? S_EXEC1 : S_FAULT;
      S_EXEC1: begin
        if (w_short)       w_next = w_end_state;
        else if (!w_stall) w_next = S_EXEC2;
      end
      S_EXEC2:  if (!w_stall) w_next = w_end_state;
      S_HALTED: w_next = S_HALTED;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_FAULT;  // unreachable encoding: trap
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_fault <= 1'b0;
    end else if (bus.clk_enable) begin
      r_state <= w_next;
      if (w_next == S_FAULT) r_fault <= 1'b1;
    end
  end

`ifdef MIPS_SEQ_PERF_COUNT_EN
  logic [31:0] r_instr_count;
  logic [31:0] r_cycle_count;
  logic        w_eoi;

  // End of instruction: SHORT leaving EXEC1, or EXEC2 not held
  assign w_eoi = ((r_state == S_EXEC1) && w_short)
              || ((r_state == S_EXEC2) && !w_stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_count <= 32'h0;
      r_cycle_count <= 32'h0;
    end else if (bus.clk_enable) begin
      if (w_active) r_cycle_count <= r_cycle_count + 32'd1;
      if (w_eoi)    r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign bus.instr_count = r_instr_count;
  assign bus.cycle_count = r_cycle_count;
`else
  assign bus.instr_count = 32'h0;
  assign bus.cycle_count = 32'h0;
`endif

  assign bus.state  = r_state;
  assign bus.active = w_active;
  assign bus.stall  = w_stall;
  assign bus.fault  = r_fault;

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// tb_mips_cpu_sequencer
//   Scoreboard bench: each driven cycle pushes the expected post-edge state and
//   counter values; a monitor pops and compares one entry after every edge.
module tb_mips_cpu_sequencer;

`ifdef MIPS_SEQ_PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [2:0]  st;
    logic [31:0] ic;
    logic [31:0] cc;
  } exp_t;

  logic clk;
  logic rst_n;
  mips_cpu_sequencer_if u_if ();

  mips_cpu_sequencer #(.HALT_ADDR_ZERO(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [2:0]  cur   = 3'd0;
  logic [31:0] m_ic  = 32'h0;
  logic [31:0] m_cc  = 32'h0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("state",  {29'h0, u_if.state}, {29'h0, e.st});
      chk("active", {31'h0, u_if.active}, {31'h0, (e.st >= 3'd1) && (e.st <= 3'd4)});
      chk("fault",  {31'h0, u_if.fault},  {31'h0, e.st == 3'd6});
      chk("instr_count", u_if.instr_count, e.ic);
      chk("cycle_count", u_if.cycle_count, e.cc);
    end
  end

  // One clocked cycle with the inputs currently driven: check combinational
  // stall, advance the counter model, push the expected outcome.
  task automatic step(input logic [2:0] nxt, input bit stl, input bit ret);
    exp_t e;
    #1;
    chk("stall", {31'h0, u_if.stall}, {31'h0, stl});
    if (u_if.clk_enable) begin
      if (cur >= 3'd1 && cur <= 3'd4) m_cc++;
      if (ret) m_ic++;
    end
    cur  = nxt;
    e.st = nxt;
    e.ic = PERF ? m_ic : 32'h0;
    e.cc = PERF ? m_cc : 32'h0;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_state",  {29'h0, u_if.state}, 32'h0);
    chk("rst_active", {31'h0, u_if.active}, 32'h0);
    chk("rst_stall",  {31'h0, u_if.stall}, 32'h0);
    chk("rst_fault",  {31'h0, u_if.fault}, 32'h0);
    chk("rst_instr",  u_if.instr_count, 32'h0);
    chk("rst_cycle",  u_if.cycle_count, 32'h0);
    cur  = 3'd0;
    m_ic = 32'h0;
    m_cc = 32'h0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic wr, input logic pcz);
    u_if.opcode          = op;
    u_if.fncode          = fn;
    u_if.mem_waitrequest = wr;
    u_if.pc_is_zero      = pcz;
  endtask

  initial begin
    rst_n           = 1'b0;
    u_if.clk_enable = 1'b1;
    set_in(6'h00, 6'h21, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_pulse();

    // addu, no wait states: 0,1,2,3,4,1
    step(3'd1, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b0);
    step(3'd3, 1'b0, 1'b0);
    step(3'd4, 1'b0, 1'b0);
    step(3'd1, 1'b0, 1'b1);

    // lw: 2 wait cycles in FETCH, 3 in EXEC1
    set_in(6'h23, 6'h00, 1'b1, 1'b0);
    step(3'd1, 1'b1, 1'b0);
    step(3'd1, 1'b1, 1'b0);
    u_if.mem_waitrequest = 1'b0;
    step(3'd2, 1'b0, 1'b0);
    step(3'd3, 1'b0, 1'b0);
    u_if.mem_waitrequest = 1'b1;
    step(3'd3, 1'b1, 1'b0);
    step(3'd3, 1'b1, 1'b0);
    step(3'd3, 1'b1, 1'b0);
    u_if.mem_waitrequest = 1'b0;
    step(3'd4, 1'b0, 1'b0);
    step(3'd1, 1'b0, 1'b1);

    // R-type fncode 0x26: upper edge of the LONG range
    set_in(6'h00, 6'h26, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b0);
    step(3'd3, 1'b0, 1'b0);
    step(3'd4, 1'b0, 1'b0);
    step(3'd1, 1'b0, 1'b1);

    // beq (waitrequest in DECODE ignored), then JR with pc_is_zero -> HALTED
    set_in(6'h04, 6'h00, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b0);
    u_if.mem_waitrequest = 1'b1;
    step(3'd3, 1'b0, 1'b0);
    u_if.mem_waitrequest = 1'b0;
    step(3'd1, 1'b0, 1'b1);
    set_in(6'h00, 6'h08, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b0);
    step(3'd3, 1'b0, 1'b0);
    u_if.pc_is_zero = 1'b1;
    step(3'd5, 1'b0, 1'b1);
    step(3'd5, 1'b0, 1'b0);
    step(3'd5, 1'b0, 1'b0);

    // opcode 0x3F -> FAULT, sticky; waitrequest there does not stall
    rst_pulse();
    set_in(6'h3f, 6'h00, 1'b0, 1'b0);
    step(3'd1, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b0);
    step(3'd6, 1'b0, 1'b0);
    u_if.mem_waitrequest = 1'b1;
    step(3'd6, 1'b0, 1'b0);
    step(3'd6, 1'b0, 1'b0);

    // R-type fncode 0x27: just past the LONG range -> FAULT
    rst_pulse();
    set_in(6'h00, 6'h27, 1'b0, 1'b0);
    step(3'd1, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b0);
    step(3'd6, 1'b0, 1'b0);

    // sw: freeze 4 cycles in EXEC1, then held EXEC2, then async reset
    rst_pulse();
    set_in(6'h2b, 6'h00, 1'b0, 1'b0);
    step(3'd1, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b0);
    step(3'd3, 1'b0, 1'b0);
    u_if.clk_enable = 1'b0;
    for (int i = 0; i < 4; i++) step(3'd3, 1'b0, 1'b0);
    u_if.clk_enable = 1'b1;
    step(3'd4, 1'b0, 1'b0);
    u_if.mem_waitrequest = 1'b1;
    step(3'd4, 1'b1, 1'b0);
    step(3'd4, 1'b1, 1'b0);
    rst_pulse();
    u_if.mem_waitrequest = 1'b0;
    step(3'd1, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b0);
    step(3'd3, 1'b0, 1'b0);
    step(3'd4, 1'b0, 1'b0);
    step(3'd1, 1'b0, 1'b1);

    chk("sb_drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
